// File: rtl/pio_bank_pkg.sv
// -----------------------------------------------------------------------------
// pio_bank_pkg
// Shared definitions for the shadowed PIO bank: per-channel register offsets,
// CTRL/STATUS placement and bit indices, and the byte-masked register update
// used by every channel.
// -----------------------------------------------------------------------------
package pio_bank_pkg;

  // Each channel occupies four consecutive words.
  localparam int CH_STRIDE = 4;

  // Word offset inside a channel window; the offset selects the update op.
  typedef enum logic [1:0] {
    OFS_DATA = 2'd0,
    OFS_SET  = 2'd1,
    OFS_CLR  = 2'd2,
    OFS_TGL  = 2'd3
  } ch_ofs_e;

  // CTRL and STATUS sit directly after the last channel window
  // (at CH_STRIDE*NUM_CH + offset).
  localparam int CTRL_OFS   = 0;
  localparam int STATUS_OFS = 1;

  // CTRL bit indices.
  localparam int CTRL_AUTO    = 0;
  localparam int CTRL_COMMIT  = 1;
  localparam int CTRL_SYNC_EN = 2;

  // STATUS bit indices.
  localparam int STATUS_PENDING = 0;

  // Expand the 4-bit byte enable into a 32-bit bit mask.
  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[b*8 +: 8] = {8{be[b]}};
    end
    return m;
  endfunction

  // Apply one register op to the current value; bytes not enabled keep
  // their old contents.
  function automatic logic [31:0] apply_op(input ch_ofs_e     op,
                                           input logic [31:0] cur,
                                           input logic [31:0] wd,
                                           input logic [3:0]  be);
    logic [31:0] res;
    logic [31:0] m;
    res = cur;
    unique case (op)
      OFS_DATA: res = wd;
      OFS_SET:  res = cur | wd;
      OFS_CLR:  res = cur & ~wd;
      OFS_TGL:  res = cur ^ wd;
    endcase
    m = byte_mask(be);
    return (res & m) | (cur & ~m);
  endfunction

endpackage

// File: rtl/pio_channel.sv
// -----------------------------------------------------------------------------
// pio_channel
// One output channel: a shadow register written by the bus and an active
// register driven to the pins. The active register either follows the shadow
// immediately (auto mode) or is loaded from the pre-edge shadow on commit.
//
// Ports
//   clk, reset   : clock, synchronous active-high reset
//   wr_en        : bus write targets this channel this cycle
//   wr_op        : DATA / SET / CLR / TGL
//   wr_data      : 32-bit bus write data
//   byteenable   : per-byte write enable
//   auto_mode    : active follows shadow on every write
//   commit       : load active from shadow (value before this edge's write)
//   shadow       : current shadow value
//   active       : current active (output) value
// -----------------------------------------------------------------------------
module pio_channel
  import pio_bank_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  ch_ofs_e           wr_op,
  input  logic [31:0]       wr_data,
  input  logic [3:0]        byteenable,
  input  logic              auto_mode,
  input  logic              commit,
  output logic [DATA_W-1:0] shadow,
  output logic [DATA_W-1:0] active
);

  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [DATA_W-1:0] active_q, active_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    shadow_d = shadow_q;
    active_d = active_q;
    if (wr_en) begin
      shadow_d = DATA_W'(apply_op(wr_op, 32'(shadow_q), wr_data, byteenable));
    end
    // A commit wins over the auto path and takes the shadow as it was before
    // this edge, so a coincident write stays in the shadow only.
    if (commit) begin
      active_d = shadow_q;
    end else if (wr_en && auto_mode) begin
      active_d = shadow_d;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block ordering.
    if (reset) begin
      shadow_q <= RESET_VAL;
      active_q <= RESET_VAL;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign shadow = shadow_q;
  assign active = active_q;

endmodule

// File: rtl/pio_shadow_bank.sv
// -----------------------------------------------------------------------------
// pio_shadow_bank
// Bank of NUM_CH shadowed output channels behind a word-addressed slave port.
// Writes update per-channel shadows; in auto mode the outputs follow at once,
// otherwise they are committed together by a CTRL COMMIT write, by
// sync_pulse (when SYNC_EN), or by switching AUTO back on while pending.
//
// Ports
//   clk, reset    : clock, synchronous active-high reset
//   address       : word address (channels, then CTRL, then STATUS)
//   chipselect    : slave select
//   write_n       : active-low write strobe
//   writedata     : write data
//   byteenable    : per-byte write enable
//   readdata      : combinational read data, zero-extended
//   sync_pulse    : external commit event
//   out_port      : active values, channel c at [c*DATA_W +: DATA_W]
//   pending       : shadows hold uncommitted writes
//   commit_pulse  : one-cycle strobe the cycle after a commit
// -----------------------------------------------------------------------------
module pio_shadow_bank
  import pio_bank_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                NUM_CH    = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  localparam int               ADDR_W    = $clog2(4*NUM_CH+2)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        address,
  input  logic                     chipselect,
  input  logic                     write_n,
  input  logic [31:0]              writedata,
  input  logic [3:0]               byteenable,
  output logic [31:0]              readdata,
  input  logic                     sync_pulse,
  output logic [NUM_CH*DATA_W-1:0] out_port,
  output logic                     pending,
  output logic                     commit_pulse
);

  localparam int                CH_W        = ADDR_W - 2;
  localparam logic [ADDR_W-1:0] CH_END      = ADDR_W'(CH_STRIDE*NUM_CH);
  localparam logic [ADDR_W-1:0] CTRL_ADDR   = ADDR_W'(CH_STRIDE*NUM_CH + CTRL_OFS);
  localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(CH_STRIDE*NUM_CH + STATUS_OFS);

  logic auto_q,    auto_d;
  logic sync_en_q, sync_en_d;
  logic pending_q, pending_d;
  logic commit_pulse_q;

  logic [DATA_W-1:0] shadow [NUM_CH];
  logic [DATA_W-1:0] active [NUM_CH];
  logic [NUM_CH-1:0] ch_wr_en;

  logic            bus_wr, ch_wr, ctrl_wr, commit;
  logic [CH_W-1:0] ch_sel;
  ch_ofs_e         ch_op;

  assign bus_wr  = chipselect & ~write_n;
  assign ch_sel  = address[ADDR_W-1:2];
  assign ch_op   = ch_ofs_e'(address[1:0]);
  assign ch_wr   = bus_wr && (address < CH_END);
  // CTRL bits all live in byte 0.
  assign ctrl_wr = bus_wr && (address == CTRL_ADDR) && byteenable[0];

  // The sync term needs pending, so a held sync_pulse commits only once per
  // batch of writes.
  assign commit = (ctrl_wr && writedata[CTRL_COMMIT])
                | (sync_pulse && sync_en_q && pending_q)
                | (ctrl_wr && writedata[CTRL_AUTO] && !auto_q && pending_q);

  always_comb begin
    ch_wr_en = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_wr_en[c] = ch_wr && (ch_sel == CH_W'(c));
    end
  end

  always_comb begin
    auto_d    = auto_q;
    sync_en_d = sync_en_q;
    if (ctrl_wr) begin
      auto_d    = writedata[CTRL_AUTO];
      sync_en_d = writedata[CTRL_SYNC_EN];
    end
    // A write coincident with a commit lands in the shadow only, so it keeps
    // pending set.
    pending_d = (ch_wr && !auto_q) || (pending_q && !commit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      auto_q         <= 1'b1;
      sync_en_q      <= 1'b0;
      pending_q      <= 1'b0;
      commit_pulse_q <= 1'b0;
    end else begin
      auto_q         <= auto_d;
      sync_en_q      <= sync_en_d;
      pending_q      <= pending_d;
      commit_pulse_q <= commit;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pio_channel #(
      .DATA_W    (DATA_W),
      .RESET_VAL (RESET_VAL)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (ch_wr_en[c]),
      .wr_op      (ch_op),
      .wr_data    (writedata),
      .byteenable (byteenable),
      .auto_mode  (auto_q),
      .commit     (commit),
      .shadow     (shadow[c]),
      .active     (active[c])
    );
    assign out_port[c*DATA_W +: DATA_W] = active[c];
  end

  // SET/CLR/TGL offsets read back the shadow just like DATA.
  always_comb begin
    readdata = '0;
    if (address < CH_END) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_sel == CH_W'(c)) readdata = 32'(shadow[c]);
      end
    end else if (address == CTRL_ADDR) begin
      readdata[CTRL_AUTO]    = auto_q;
      readdata[CTRL_SYNC_EN] = sync_en_q;
    end else if (address == STATUS_ADDR) begin
      readdata[STATUS_PENDING] = pending_q;
    end
  end

  assign pending      = pending_q;
  assign commit_pulse = commit_pulse_q;

endmodule

// File: tb/tb_pio_shadow_bank.sv
// -----------------------------------------------------------------------------
// tb_pio_shadow_bank
// Bench for pio_shadow_bank (DATA_W=16, NUM_CH=4, RESET_VAL=0). A byte-level
// behavioural model tracks shadows, outputs, CTRL and pending; one process
// compares every output on each falling edge, and directed sequences pin the
// model with literal values before a randomized run.
// -----------------------------------------------------------------------------
module tb_pio_shadow_bank;

  localparam int DATA_W = 16;
  localparam int NUM_CH = 4;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic [31:0]       readdata;
  logic              sync_pulse;
  logic [63:0]       out_port;
  logic              pending;
  logic              commit_pulse;

  always #5 clk = ~clk;

  pio_shadow_bank #(
    .DATA_W    (DATA_W),
    .NUM_CH    (NUM_CH),
    .RESET_VAL (16'h0000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .address      (address),
    .chipselect   (chipselect),
    .write_n      (write_n),
    .writedata    (writedata),
    .byteenable   (byteenable),
    .readdata     (readdata),
    .sync_pulse   (sync_pulse),
    .out_port     (out_port),
    .pending      (pending),
    .commit_pulse (commit_pulse)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Behavioural model state.
  logic [15:0] m_shadow [4];
  logic [15:0] m_active [4];
  bit          m_auto, m_sync_en, m_pending, m_cpulse;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [ADDR_W-1:0] a);
    int ai;
    ai = int'(a);
    if (ai < 16) return {16'h0, m_shadow[ai/4]};
    if (ai == 16) return {29'h0, m_sync_en, 1'b0, m_auto};
    if (ai == 17) return {31'h0, m_pending};
    return 32'h0;
  endfunction

  function automatic logic [63:0] model_out();
    return {m_active[3], m_active[2], m_active[1], m_active[0]};
  endfunction

  // Advance the model by one rising edge from the inputs currently applied.
  task automatic model_edge();
    bit          wr, ch_w, ctrl_w, commit;
    int          ch, kind;
    logic [15:0] old_sh [4];
    logic [7:0]  s, w;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        m_shadow[i] = 16'h0;
        m_active[i] = 16'h0;
      end
      m_auto    = 1'b1;
      m_sync_en = 1'b0;
      m_pending = 1'b0;
      m_cpulse  = 1'b0;
      return;
    end
    wr     = chipselect && !write_n;
    ch_w   = wr && (int'(address) < 16);
    ctrl_w = wr && (int'(address) == 16) && byteenable[0];
    ch     = int'(address) / 4;
    kind   = int'(address) % 4;
    old_sh = m_shadow;
    commit = (ctrl_w && writedata[1])
          || (sync_pulse && m_sync_en && m_pending)
          || (ctrl_w && writedata[0] && !m_auto && m_pending);
    if (ch_w) begin
      for (int b = 0; b < 2; b++) begin
        if (byteenable[b]) begin
          s = m_shadow[ch][8*b +: 8];
          w = writedata[8*b +: 8];
          case (kind)
            0:       s = w;
            1:       s = s | w;
            2:       s = s & ~w;
            default: s = s ^ w;
          endcase
          m_shadow[ch][8*b +: 8] = s;
        end
      end
    end
    if (commit) m_active = old_sh;
    else if (ch_w && m_auto) m_active[ch] = m_shadow[ch];
    if (ch_w && !m_auto) m_pending = 1'b1;
    else if (commit) m_pending = 1'b0;
    if (ctrl_w) begin
      m_auto    = writedata[0];
      m_sync_en = writedata[2];
    end
    m_cpulse = commit;
  endtask

  // Single compare process: every falling edge while enabled.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("out_port", out_port, model_out());
      check("pending", {63'h0, pending}, {63'h0, m_pending});
      check("commit_pulse", {63'h0, commit_pulse}, {63'h0, m_cpulse});
      check("readdata", {32'h0, readdata}, {32'h0, model_read(address)});
    end
  end

  // Apply one cycle of inputs; called just after a rising edge.
  task automatic step(input logic r, input logic cs, input logic wn,
                      input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input logic sp);
    reset = r; chipselect = cs; write_n = wn; address = a;
    writedata = wd; byteenable = be; sync_pulse = sp;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                    input logic [3:0] be, input logic sp);
    step(1'b0, 1'b1, 1'b0, a, wd, be, sp);
  endtask

  task automatic idle(input logic sp);
    step(1'b0, 1'b0, 1'b1, '0, 32'h0, 4'h0, sp);
  endtask

  // Read with a literal expectation, then spend the cycle.
  task automatic rd_expect(input string name, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
    reset = 1'b0; chipselect = 1'b1; write_n = 1'b1; address = a;
    writedata = 32'h0; byteenable = 4'h0; sync_pulse = 1'b0;
    #1;
    check(name, {32'h0, readdata}, {32'h0, exp});
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    int pulses;

    // Reset state.
    step(1'b1, 1'b0, 1'b1, '0, 32'h0, 4'h0, 1'b0);
    cmp_en = 1'b1;
    step(1'b1, 1'b0, 1'b1, '0, 32'h0, 4'h0, 1'b0);
    check("rst_out", out_port, 64'h0);
    check("rst_pending", {63'h0, pending}, 64'h0);
    rd_expect("rst_ctrl", 5'd16, 32'h1);

    // Auto mode: ch1 follows the write at the same edge.
    wr(5'd4, 32'h0000_1234, 4'hF, 1'b0);
    check("auto_ch1", {48'h0, out_port[31:16]}, 64'h1234);
    check("auto_pending", {63'h0, pending}, 64'h0);

    // Manual mode: build 0x0FEE in ch0, outputs hold until COMMIT.
    wr(5'd16, 32'h0, 4'hF, 1'b0);
    wr(5'd0, 32'h0000_00FF, 4'hF, 1'b0);
    wr(5'd1, 32'h0000_0F00, 4'hF, 1'b0);
    wr(5'd3, 32'h0000_0011, 4'hF, 1'b0);
    check("man_ch0_hold", {48'h0, out_port[15:0]}, 64'h0);
    check("man_pending", {63'h0, pending}, 64'h1);
    rd_expect("man_readback", 5'd0, 32'h0FEE);
    rd_expect("man_readback_tgl", 5'd3, 32'h0FEE);
    rd_expect("status_pending", 5'd17, 32'h1);
    wr(5'd16, 32'h2, 4'hF, 1'b0);
    check("commit_ch0", {48'h0, out_port[15:0]}, 64'h0FEE);
    check("commit_pulse_hi", {63'h0, commit_pulse}, 64'h1);
    check("commit_clears", {63'h0, pending}, 64'h0);
    idle(1'b0);
    check("commit_pulse_lo", {63'h0, commit_pulse}, 64'h0);

    // Held sync_pulse commits exactly once.
    wr(5'd16, 32'h4, 4'hF, 1'b0);
    wr(5'd12, 32'h0000_BEEF, 4'hF, 1'b0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      if (commit_pulse) pulses++;
    end
    idle(1'b0);
    if (commit_pulse) pulses++;
    check("sync_once", 64'(pulses), 64'd1);
    check("sync_ch3", {48'h0, out_port[63:48]}, 64'hBEEF);
    check("sync_pending", {63'h0, pending}, 64'h0);

    // Write coincident with sync commit stays in the shadow.
    wr(5'd8, 32'h0000_AAAA, 4'hF, 1'b0);
    wr(5'd8, 32'h0000_5555, 4'hF, 1'b1);
    check("coinc_out", {48'h0, out_port[47:32]}, 64'hAAAA);
    check("coinc_pending", {63'h0, pending}, 64'h1);
    rd_expect("coinc_shadow", 5'd8, 32'h5555);

    // Byte enables, unmapped addresses, then reset while pending.
    wr(5'd0, 32'h0, 4'hF, 1'b0);
    wr(5'd0, 32'h0000_FFFF, 4'b0010, 1'b0);
    rd_expect("be_shadow", 5'd0, 32'hFF00);
    wr(5'd20, 32'hFFFF_FFFF, 4'hF, 1'b0);
    rd_expect("unmapped_rd", 5'd20, 32'h0);
    wr(5'd17, 32'hFFFF_FFFF, 4'hF, 1'b0);
    rd_expect("status_ro", 5'd17, 32'h1);
    step(1'b1, 1'b1, 1'b0, 5'd16, 32'h3, 4'hF, 1'b1);
    check("rst_mid_out", out_port, 64'h0);
    check("rst_mid_pending", {63'h0, pending}, 64'h0);
    check("rst_mid_pulse", {63'h0, commit_pulse}, 64'h0);
    rd_expect("rst_mid_ctrl", 5'd16, 32'h1);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [ADDR_W-1:0] a;
      logic [31:0]       wd;
      a  = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(16, 31))
                                        : ADDR_W'($urandom_range(0, 15));
      wd = $urandom;
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), a, wd, 4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0));
    end
    idle(1'b0);
    @(negedge clk);
    #1;
    cmp_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pio_shadow_bank.md
PIO_SHADOW_BANK -- requirements
Module: pio_shadow_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of each channel in bits (1..32).
REQ-002 SHALL have parameter NUM_CH, default 4, number of output channels (1..16).
REQ-003 SHALL have parameter RESET_VAL, default 0, reset value of every channel register (DATA_W bits).
REQ-004 SHALL derive ADDR_W = clog2(4*NUM_CH+2) for the word address width.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 address  in  ADDR_W  word address.
REQ-008 chipselect  in  1  slave select.
REQ-009 write_n  in  1  active-low write strobe; write = chipselect & ~write_n.
REQ-010 writedata  in  32  write data.
REQ-011 byteenable  in  4  per-byte write enable.
REQ-012 readdata  out  32  combinational read data, latency 0, zero-extended.
REQ-013 sync_pulse  in  1  external commit event, e.g. VGA vsync.
REQ-014 out_port  out  NUM_CH*DATA_W  active values; channel c at bits [c*DATA_W +: DATA_W].
REQ-015 pending  out  1  shadow differs from committed state.
REQ-016 commit_pulse  out  1  one-cycle strobe after a manual or sync commit.

Function
REQ-017 Map per channel c, base 4c: +0 DATA (write/read shadow), +1 SET, +2 CLR, +3 TGL (writes only; reads return shadow).
REQ-018 Map 4*NUM_CH: CTRL (bit0 AUTO, bit1 COMMIT write-1-pulse reads 0, bit2 SYNC_EN); 4*NUM_CH+1: STATUS (bit0 pending, read-only).
REQ-019 DATA write: shadow <= writedata per enabled byte; SET: shadow |= wd; CLR: shadow &= ~wd; TGL: shadow ^= wd; disabled bytes and bits >= DATA_W unaffected.
REQ-020 Unmapped addresses SHALL read 0 and ignore writes; reads SHALL have no side effects.
REQ-021 AUTO=1: out_port of the written channel SHALL take the new shadow value at the same edge; pending stays 0; no commit_pulse.
REQ-022 AUTO=0: shadow writes SHALL not change out_port and SHALL set pending at that edge.
REQ-023 Commit trigger = CTRL write with COMMIT=1, or sync_pulse=1 while SYNC_EN=1 and pending=1, or CTRL write setting AUTO 0->1 while pending=1.
REQ-024 At a commit edge, all channels' out_port <= shadow value before that edge's write; commit_pulse=1 the following cycle only.
REQ-025 Shadow write coincident with commit: write SHALL land in shadow only; pending SHALL remain 1.
REQ-026 Commit with no coincident write SHALL clear pending; COMMIT with pending=0 SHALL still pulse commit_pulse.
REQ-027 sync_pulse held high multiple cycles SHALL commit once per pending episode.

Reset
REQ-028 At a reset edge: shadow and out_port = RESET_VAL for all channels, CTRL = AUTO=1/SYNC_EN=0, pending=0, commit_pulse=0.
REQ-029 Reset SHALL override any concurrent write or commit, including mid-pending.

Structure
REQ-030 Package pio_bank_pkg SHALL hold register offsets (DATA/SET/CLR/TGL, CTRL, STATUS) and CTRL bit indices.
REQ-031 Sub-module pio_channel (shadow register, active register, SET/CLR/TGL/byteenable update) SHALL be instantiated NUM_CH times; commit/pending control lives in the top.

Verification (DATA_W=16, NUM_CH=4, RESET_VAL=0)
REQ-032 Reset, write DATA ch1=0x1234 -> out_port[31:16]=0x1234 same edge, pending=0.
REQ-033 AUTO=0, write ch0=0x00FF, SET ch0 0x0F00, TGL 0x0011 -> out_port ch0 still 0, pending=1, readback 0x0FEE; COMMIT -> ch0=0x0FEE, commit_pulse one cycle.
REQ-034 AUTO=0, SYNC_EN=1, write ch3=0xBEEF, sync_pulse high 3 cycles -> exactly one commit, ch3=0xBEEF, pending=0.
REQ-035 Write ch2=0xAAAA then ch2=0x5555 coincident with sync_pulse -> out ch2=0xAAAA, shadow 0x5555, pending=1.
REQ-036 byteenable=0b0010 write 0xFFFF to ch0 holding 0 -> shadow 0xFF00; reset asserted while pending -> all outputs 0, pending=0.
